// File: rtl/io_bus_pkg.sv
// Shared decode constants and read-return selector for the cpu I/O bridge.
package io_bus_pkg;

  // Value of cpu_a_i[17:16] that selects the memory-mapped I/O window.
  localparam logic [1:0] IO_BASE_SEL = 2'b11;

  // Offsets within the I/O window, taken from cpu_a_i[2:0].
  localparam logic [2:0] OFF_UART = 3'd0;
  localparam logic [2:0] OFF_CNT  = 3'd4;

  // Source of the byte returned on cpu_din_o in the cycle after a read.
  typedef enum logic [2:0] {
    RD_RAM,
    RD_RX,
    RD_CNT0,
    RD_CNT1,
    RD_CNT2,
    RD_CNT3,
    RD_ZERO
  } rd_sel_e;

endpackage

// File: rtl/io_tx_fifo.sv
// Byte FIFO that buffers UART TX writes; the head entry is presented directly.
module io_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  logic [7:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Pointer and occupancy update; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage written at the tail.
  // NOTE: storage is deliberately not reset; the pointers and count define what is valid.
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/io_bus_bridge.sv
// Splits the cpu byte bus between RAM and the I/O window (UART RX/TX, cycle counter, stop flag).
module io_bus_bridge
  import io_bus_pkg::*;
#(
  parameter int TX_DEPTH = 8,
  parameter int TX_AW    = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a_i,
  input  logic [7:0]  cpu_dout_i,
  input  logic        cpu_wr_i,
  output logic [7:0]  cpu_din_o,
  output logic        cpu_rdy_o,
  output logic [16:0] ram_a_o,
  output logic [7:0]  ram_dout_o,
  output logic        ram_we_o,
  input  logic [7:0]  ram_din_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_pop_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        prog_stop_o
);

  logic       io;
  logic [2:0] io_off;
  logic       uart_wr, stop_wr, push_req;
  logic       tx_pop, tx_push, fifo_full, fifo_empty;
  logic [7:0] push_data;
  logic       rd_acc;
  logic       unused_addr_hi;

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] snap_q, snap_d;
  logic        prog_stop_q, prog_stop_d;
  rd_sel_e     rd_sel_q, rd_sel_d;
  logic        rd_pend_q, rd_pend_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_pop_q, rx_pop_d;

  assign unused_addr_hi = ^cpu_a_i[31:18];

  assign io     = (cpu_a_i[17:16] == IO_BASE_SEL);
  assign io_off = cpu_a_i[2:0];

  // A zero byte to the UART is dropped, so it never pushes nor stalls; a stop write pushes 0x00.
  assign uart_wr   = io & cpu_wr_i & (io_off == OFF_UART) & (cpu_dout_i != 8'h00);
  assign stop_wr   = io & cpu_wr_i & (io_off == OFF_CNT);
  assign push_req  = uart_wr | stop_wr;
  assign push_data = stop_wr ? 8'h00 : cpu_dout_i;

  // A simultaneous pop frees a slot, so a full FIFO only stalls when the UART is not draining it.
  assign tx_pop    = tx_valid_o & tx_ready_i;
  assign cpu_rdy_o = !(push_req & fifo_full & !tx_pop);
  assign tx_push   = push_req & cpu_rdy_o;
  assign rd_acc    = cpu_rdy_o & !cpu_wr_i;

  assign ram_a_o    = cpu_a_i[16:0];
  assign ram_dout_o = cpu_dout_i;
  assign ram_we_o   = rst_in & !io & cpu_wr_i & cpu_rdy_o;

  io_tx_fifo #(
    .DEPTH (TX_DEPTH),
    .AW    (TX_AW)
  ) u_tx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (tx_push),
    .push_data (push_data),
    .pop       (tx_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (tx_data_o)
  );

  assign tx_valid_o = !fifo_empty;

  // Next-state for counter, stop flag and the read-return selector.
  always_comb begin
    cnt_d       = prog_stop_q ? cnt_q : cnt_q + 32'd1;
    prog_stop_d = prog_stop_q | stop_wr & cpu_rdy_o;
    snap_d      = snap_q;
    rd_sel_d    = rd_sel_q;
    rd_pend_d   = rd_acc;
    rx_byte_d   = rx_byte_q;
    rx_pop_d    = 1'b0;
    if (rd_acc) begin
      if (!io) begin
        rd_sel_d = RD_RAM;
      end else begin
        case (io_off)
          OFF_UART: begin
            rd_sel_d  = RD_RX;
            rx_byte_d = rx_valid_i ? rx_data_i : 8'h00;
            rx_pop_d  = rx_valid_i;
          end
          // Offset 4 refreshes the snapshot so bytes 5..7 read back a coherent value.
          OFF_CNT: begin
            rd_sel_d = RD_CNT0;
            snap_d   = cnt_q;
          end
          3'd5:    rd_sel_d = RD_CNT1;
          3'd6:    rd_sel_d = RD_CNT2;
          3'd7:    rd_sel_d = RD_CNT3;
          default: rd_sel_d = RD_ZERO;
        endcase
      end
    end
  end

  // State register; reset discards any pending read and stops the counter at zero.
  always_ff @(posedge clk_in or negedge rst_in) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_in) begin
      cnt_q       <= '0;
      snap_q      <= '0;
      prog_stop_q <= 1'b0;
      rd_sel_q    <= RD_RAM;
      rd_pend_q   <= 1'b0;
      rx_byte_q   <= '0;
      rx_pop_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      snap_q      <= snap_d;
      prog_stop_q <= prog_stop_d;
      rd_sel_q    <= rd_sel_d;
      rd_pend_q   <= rd_pend_d;
      rx_byte_q   <= rx_byte_d;
      rx_pop_q    <= rx_pop_d;
    end
  end

  // Read-return mux, active only in the cycle after an accepted read.
  always_comb begin
    cpu_din_o = 8'h00;
    if (rd_pend_q) begin
      case (rd_sel_q)
        RD_RAM:  cpu_din_o = ram_din_i;
        RD_RX:   cpu_din_o = rx_byte_q;
        RD_CNT0: cpu_din_o = snap_q[7:0];
        RD_CNT1: cpu_din_o = snap_q[15:8];
        RD_CNT2: cpu_din_o = snap_q[23:16];
        RD_CNT3: cpu_din_o = snap_q[31:24];
        default: cpu_din_o = 8'h00;
      endcase
    end
  end

  assign rx_pop_o    = rx_pop_q;
  assign prog_stop_o = prog_stop_q;

endmodule

// File: tb/tb_io_bus_bridge.sv
// Self-checking bench for io_bus_bridge: a queue/arithmetic model checked every cycle plus literal checks.
module tb_io_bus_bridge;

  localparam int TX_DEPTH = 8;

  logic        clk_in, rst_in;
  logic [31:0] cpu_a_i;
  logic [7:0]  cpu_dout_i;
  logic        cpu_wr_i;
  logic [7:0]  cpu_din_o;
  logic        cpu_rdy_o;
  logic [16:0] ram_a_o;
  logic [7:0]  ram_dout_o;
  logic        ram_we_o;
  logic [7:0]  ram_din_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_pop_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        prog_stop_o;

  io_bus_bridge #(.TX_DEPTH(TX_DEPTH), .TX_AW(3)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .cpu_a_i     (cpu_a_i),
    .cpu_dout_i  (cpu_dout_i),
    .cpu_wr_i    (cpu_wr_i),
    .cpu_din_o   (cpu_din_o),
    .cpu_rdy_o   (cpu_rdy_o),
    .ram_a_o     (ram_a_o),
    .ram_dout_o  (ram_dout_o),
    .ram_we_o    (ram_we_o),
    .ram_din_i   (ram_din_i),
    .rx_data_i   (rx_data_i),
    .rx_valid_i  (rx_valid_i),
    .rx_pop_o    (rx_pop_o),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .prog_stop_o (prog_stop_o)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  mq[$];
  logic [31:0] m_cnt, m_snap;
  logic        m_stop, m_pend, m_is_ram, m_pop;
  logic [7:0]  m_byte;

  function automatic logic m_io();
    return cpu_a_i[17:16] == 2'b11;
  endfunction

  function automatic logic m_push_req();
    return m_io() && cpu_wr_i &&
           ((cpu_a_i[2:0] == 3'd0 && cpu_dout_i != 8'h00) || cpu_a_i[2:0] == 3'd4);
  endfunction

  function automatic logic m_rdy();
    logic full, draining;
    full     = (mq.size() == TX_DEPTH);
    draining = (mq.size() != 0) && tx_ready_i;
    return !(m_push_req() && full && !draining);
  endfunction

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mq.delete();
      m_cnt = 0; m_snap = 0; m_stop = 0;
      m_pend = 0; m_is_ram = 0; m_pop = 0; m_byte = 0;
    end else begin
      logic rdy, drain;
      int   off;
      rdy   = m_rdy();
      drain = (mq.size() != 0) && tx_ready_i;
      off   = int'(cpu_a_i[2:0]);
      m_pop  = 0;
      m_pend = rdy && !cpu_wr_i;
      if (m_pend) begin
        m_is_ram = !m_io();
        m_byte   = 8'h00;
        if (m_io()) begin
          if (off == 0) begin
            m_byte = rx_valid_i ? rx_data_i : 8'h00;
            m_pop  = rx_valid_i;
          end else if (off >= 4) begin
            if (off == 4) m_snap = m_cnt;
            m_byte = 8'(m_snap >> (8 * (off - 4)));
          end
        end
      end
      if (drain) void'(mq.pop_front());
      if (rdy && m_push_req()) mq.push_back(off == 4 ? 8'h00 : cpu_dout_i);
      if (!m_stop) m_cnt = m_cnt + 1;
      if (rdy && m_io() && cpu_wr_i && off == 4) m_stop = 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk_in) begin
    if (rst_in) begin
      check("tx_valid", 32'(tx_valid_o), 32'(mq.size() != 0));
      if (mq.size() != 0) check("tx_data", 32'(tx_data_o), 32'(mq[0]));
      check("prog_stop", 32'(prog_stop_o), 32'(m_stop));
      check("cpu_rdy", 32'(cpu_rdy_o), 32'(m_rdy()));
      check("ram_we", 32'(ram_we_o), 32'(!m_io() && cpu_wr_i && m_rdy()));
      if (!m_io()) begin
        check("ram_a", 32'(ram_a_o), 32'(cpu_a_i[16:0]));
        check("ram_dout", 32'(ram_dout_o), 32'(cpu_dout_i));
      end
      check("rx_pop", 32'(rx_pop_o), 32'(m_pop));
      if (m_pend) check("cpu_din", 32'(cpu_din_o), 32'(m_is_ram ? ram_din_i : m_byte));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [31:0] a, input logic [7:0] d, input logic wr);
    cpu_a_i = a; cpu_dout_i = d; cpu_wr_i = wr;
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    drive(32'h0, 8'h00, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b0;
    idle();
    ram_din_i = 8'h00; rx_data_i = 8'h00; rx_valid_i = 1'b0; tx_ready_i = 1'b0;
    #3;
    check("rst_cpu_din", 32'(cpu_din_o), 32'h0);
    check("rst_ram_we", 32'(ram_we_o), 32'h0);
    check("rst_rx_pop", 32'(rx_pop_o), 32'h0);
    check("rst_tx_valid", 32'(tx_valid_o), 32'h0);
    check("rst_prog_stop", 32'(prog_stop_o), 32'h0);
    check("rst_cpu_rdy", 32'(cpu_rdy_o), 32'h1);
    @(negedge clk_in);
    rst_in = 1'b1;

    // Counter snapshot: 100 edges elapsed, so the offset-4 read captures 100.
    repeat (100) cyc();
    drive(32'h30004, 8'h00, 1'b0); cyc(); idle();
    check("cnt_b0", 32'(cpu_din_o), 32'h64);
    cyc();
    drive(32'h30005, 8'h00, 1'b0); cyc(); idle();
    check("cnt_b1", 32'(cpu_din_o), 32'h00);
    cyc();
    drive(32'h30006, 8'h00, 1'b0); cyc(); idle();
    check("cnt_b2", 32'(cpu_din_o), 32'h00);
    cyc();
    drive(32'h30007, 8'h00, 1'b0); cyc(); idle();
    check("cnt_b3", 32'(cpu_din_o), 32'h00);
    cyc();

    // RAM read with one-cycle data return.
    ram_din_i = 8'hA5;
    drive(32'h00010, 8'h00, 1'b0);
    #1 check("ram_rd_addr", 32'(ram_a_o), 32'h10);
    check("ram_rd_we", 32'(ram_we_o), 32'h0);
    cyc(); idle();
    check("ram_rd_data", 32'(cpu_din_o), 32'hA5);
    cyc();
    ram_din_i = 8'h00;

    // TX writes with the UART blocked; the zero byte is dropped.
    drive(32'h30000, 8'h48, 1'b1); cyc();
    drive(32'h30000, 8'h69, 1'b1); cyc();
    drive(32'h30000, 8'h00, 1'b1);
    #1 check("tx_zero_rdy", 32'(cpu_rdy_o), 32'h1);
    cyc(); idle();
    check("tx_head_H", 32'(tx_data_o), 32'h48);
    check("tx_valid_2", 32'(tx_valid_o), 32'h1);
    for (int i = 1; i <= 6; i++) begin
      drive(32'h30000, 8'(8'h30 + i), 1'b1); cyc();
    end
    // FIFO now full: the next nonzero write stalls until the UART drains one entry.
    drive(32'h30000, 8'h77, 1'b1);
    #1 check("stall_rdy0", 32'(cpu_rdy_o), 32'h0);
    repeat (3) cyc();
    check("stall_hold", 32'(cpu_rdy_o), 32'h0);
    tx_ready_i = 1'b1;
    #1 check("stall_release", 32'(cpu_rdy_o), 32'h1);
    cyc();
    tx_ready_i = 1'b0; idle();
    check("tx_head_i", 32'(tx_data_o), 32'h69);
    check("tx_still_full", 32'(mq.size()), 32'(TX_DEPTH));
    tx_ready_i = 1'b1;
    repeat (8) cyc();
    tx_ready_i = 1'b0;
    check("tx_drained", 32'(tx_valid_o), 32'h0);

    // UART RX reads with and without a byte available.
    rx_valid_i = 1'b1; rx_data_i = 8'h41;
    drive(32'h30000, 8'h00, 1'b0); cyc();
    rx_valid_i = 1'b0; rx_data_i = 8'h55; idle();
    check("rx_data", 32'(cpu_din_o), 32'h41);
    check("rx_pop_1", 32'(rx_pop_o), 32'h1);
    cyc();
    check("rx_pop_single", 32'(rx_pop_o), 32'h0);
    drive(32'h30000, 8'h00, 1'b0); cyc(); idle();
    check("rx_empty_data", 32'(cpu_din_o), 32'h00);
    check("rx_no_pop", 32'(rx_pop_o), 32'h0);
    drive(32'h30002, 8'h00, 1'b0); cyc(); idle();
    check("io_other_rd", 32'(cpu_din_o), 32'h00);

    // Stop write pushes 0x00; ignored writes; RAM write strobe.
    drive(32'h30004, 8'h99, 1'b1); cyc(); idle();
    check("stop_set", 32'(prog_stop_o), 32'h1);
    check("stop_push", 32'(tx_data_o), 32'h00);
    check("stop_valid", 32'(tx_valid_o), 32'h1);
    drive(32'h30002, 8'h12, 1'b1); cyc();
    drive(32'h30000, 8'h00, 1'b1); cyc();
    drive(32'h30004, 8'h00, 1'b1); cyc();
    check("stop_twice", 32'(mq.size()), 32'h2);
    drive(32'h00020, 8'h5A, 1'b1);
    #1 check("ram_wr_we", 32'(ram_we_o), 32'h1);
    check("ram_wr_data", 32'(ram_dout_o), 32'h5A);
    cyc();
    drive(32'h30004, 8'h00, 1'b0); cyc(); idle();
    repeat (3) cyc();
    drive(32'h30004, 8'h00, 1'b0); cyc(); idle();
    cyc();

    // Asynchronous reset in the middle of activity.
    drive(32'h00020, 8'h5A, 1'b1);
    #2 rst_in = 1'b0;
    #1;
    check("arst_tx_valid", 32'(tx_valid_o), 32'h0);
    check("arst_prog_stop", 32'(prog_stop_o), 32'h0);
    check("arst_cpu_din", 32'(cpu_din_o), 32'h0);
    check("arst_ram_we", 32'(ram_we_o), 32'h0);
    idle();
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (5) cyc();
    drive(32'h30004, 8'h00, 1'b0); cyc(); idle();
    check("arst_cnt_restart", 32'(cpu_din_o), 32'h05);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
